// File: rtl/ball_pkg.sv
// ball_pkg: shared mode/state types and fixed-point width helpers for the ball engine.
package ball_pkg;
    typedef enum logic {BOUNCE = 1'b0, EXIT = 1'b1} mode_t;
    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;
    localparam int GUARD_BITS = 2;
    function automatic int pos_w(input int w, input int frac);
        return w + frac;
    endfunction
    function automatic int guard_w(input int w, input int frac);
        return w + frac + GUARD_BITS;
    endfunction
endpackage

// File: rtl/ball_axis_step.sv
// ball_axis_step: combinational single-axis position/velocity update with bounce or exit.
module ball_axis_step
    import ball_pkg::*;
#(
    parameter int W = 16,
    parameter int FRAC = 4,
    parameter int VW = 8,
    localparam int PW = pos_w(W, FRAC),
    localparam int GW = guard_w(W, FRAC)
) (
    input  logic [PW-1:0]        pos,
    input  logic signed [VW-1:0] v,
    input  logic [PW-1:0]        lo,
    input  logic [PW-1:0]        hi,
    input  mode_t                mode,
    output logic [PW-1:0]        pos_n,
    output logic signed [VW-1:0] v_n,
    output logic                 ext
);
    localparam logic signed [VW-1:0] MINV = {1'b1, {(VW-1){1'b0}}};
    localparam logic signed [VW-1:0] MAXV = {1'b0, {(VW-1){1'b1}}};
    logic signed [GW-1:0] nxt;
    logic out;
    always_comb begin
        nxt = $signed({2'b00, pos}) + $signed({{(GW-VW){v[VW-1]}}, v});
        out = (nxt < $signed({2'b00, lo})) || (nxt > $signed({2'b00, hi}));
        ext = mode == EXIT && out;
        pos_n = !out ? nxt[PW-1:0] : (mode == EXIT) ? pos : (nxt < $signed({2'b00, lo})) ? lo : hi;
        // the most negative velocity has no positive twin, so it saturates
        v_n = (mode == BOUNCE && out) ? ((v == MINV) ? MAXV : -v) : v;
    end
endmodule

// File: rtl/ball_pool.sv
// ball_pool: N-slot projectile engine; one shared datapath sweeps every slot per animation strobe.
module ball_pool
    import ball_pkg::*;
#(
    parameter int N_BALLS = 8,
    parameter int W = 16,
    parameter int FRAC = 4,
    parameter int VW = 8,
    parameter int FX = 245,
    parameter int FY = 230,
    parameter int F_WIDTH = 150,
    parameter int F_HEIGHT = 150,
    parameter int R = 5,
    localparam int IW = (N_BALLS > 1) ? $clog2(N_BALLS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ani_stb,
    input  logic                 i_animate,
    input  logic                 i_spawn_valid,
    output logic                 o_spawn_ready,
    input  logic [W-1:0]         i_spawn_x,
    input  logic [W-1:0]         i_spawn_y,
    input  logic signed [VW-1:0] i_spawn_vx,
    input  logic signed [VW-1:0] i_spawn_vy,
    input  logic                 i_spawn_mode,
    input  logic [IW-1:0]        i_rd_idx,
    output logic [W-1:0]         o_rd_cx,
    output logic [W-1:0]         o_rd_cy,
    output logic [W-1:0]         o_rd_r,
    output logic                 o_rd_active,
    output logic [N_BALLS-1:0]   o_active,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic                 o_missed
);
    localparam int PW = pos_w(W, FRAC);
    localparam logic [PW-1:0] LO = PW'(R << FRAC);
    localparam logic [PW-1:0] HIX = PW'((F_WIDTH - R) << FRAC);
    localparam logic [PW-1:0] HIY = PW'((F_HEIGHT - R) << FRAC);
    localparam logic [W-1:0] PMIN = W'(R);
    localparam logic [W-1:0] XMAX = W'(F_WIDTH - R);
    localparam logic [W-1:0] YMAX = W'(F_HEIGHT - R);

    state_t state, state_n;
    logic [IW-1:0] idx, free_idx;
    logic [PW-1:0] px [N_BALLS];
    logic [PW-1:0] py [N_BALLS];
    logic signed [VW-1:0] vx [N_BALLS];
    logic signed [VW-1:0] vy [N_BALLS];
    mode_t md [N_BALLS];
    logic [N_BALLS-1:0] active;
    logic [PW-1:0] nx, ny;
    logic signed [VW-1:0] nvx, nvy;
    logic ex, ey, stb, last, spawn, sweep_wr;
    logic [W-1:0] sx, sy;

    assign stb = i_ani_stb && i_animate;
    assign last = state == SWEEP && idx == IW'(N_BALLS - 1);
    assign o_busy = state == SWEEP;
    assign o_spawn_ready = state == IDLE && !i_rst && !(&active);
    assign spawn = i_spawn_valid && o_spawn_ready;
    assign sweep_wr = state == SWEEP && active[idx];
    assign o_active = active;
    assign sx = (i_spawn_x < PMIN) ? PMIN : (i_spawn_x > XMAX) ? XMAX : i_spawn_x;
    assign sy = (i_spawn_y < PMIN) ? PMIN : (i_spawn_y > YMAX) ? YMAX : i_spawn_y;

    always_comb begin
        state_n = (state == IDLE && stb) ? SWEEP : last ? IDLE : state;
    end

    always_comb begin
        free_idx = '0;
        for (int i = N_BALLS - 1; i >= 0; i--)
            if (!active[i]) free_idx = IW'(i);
    end

    ball_axis_step #(.W(W), .FRAC(FRAC), .VW(VW)) u_x (
        .pos(px[idx]), .v(vx[idx]), .lo(LO), .hi(HIX), .mode(md[idx]),
        .pos_n(nx), .v_n(nvx), .ext(ex)
    );
    ball_axis_step #(.W(W), .FRAC(FRAC), .VW(VW)) u_y (
        .pos(py[idx]), .v(vy[idx]), .lo(LO), .hi(HIY), .mode(md[idx]),
        .pos_n(ny), .v_n(nvy), .ext(ey)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            idx <= '0;
            active <= '0;
            o_frame_done <= 1'b0;
            o_missed <= 1'b0;
            o_rd_cx <= '0;
            o_rd_cy <= '0;
            o_rd_r <= '0;
            o_rd_active <= 1'b0;
        end else begin
            state <= state_n;
            idx <= (state == SWEEP && !last) ? idx + 1'b1 : '0;
            o_frame_done <= last;
            o_missed <= state == SWEEP && stb;
            if (spawn) active[free_idx] <= 1'b1;
            if (sweep_wr && (ex || ey)) active[idx] <= 1'b0;
            o_rd_cx <= W'(FX) + px[i_rd_idx][PW-1 -: W];
            o_rd_cy <= W'(FY) + py[i_rd_idx][PW-1 -: W];
            o_rd_r <= W'(R);
            o_rd_active <= active[i_rd_idx];
        end
    end

    // slot storage carries no reset so it can map onto RAM
    always_ff @(posedge i_clk) begin
        if (spawn) begin
            px[free_idx] <= {sx, {FRAC{1'b0}}};
            py[free_idx] <= {sy, {FRAC{1'b0}}};
            vx[free_idx] <= i_spawn_vx;
            vy[free_idx] <= i_spawn_vy;
            md[free_idx] <= mode_t'(i_spawn_mode);
        end else if (sweep_wr) begin
            px[idx] <= nx;
            py[idx] <= ny;
            vx[idx] <= nvx;
            vy[idx] <= nvy;
        end
    end
endmodule

// File: tb/tb_ball_pool.sv
// tb_ball_pool: directed and randomized checks of ball_pool against a behavioural ball model.
module tb_ball_pool;
    localparam int N = 8, FX = 245, FY = 230, FW = 150, FH = 150, R = 5;
    localparam int LO = R * 16, HIX = (FW - R) * 16, HIY = (FH - R) * 16;

    logic clk = 0, rst = 1, ani_stb = 0, animate = 1, spawn_valid = 0, spawn_mode = 0;
    logic spawn_ready, rd_active, busy, frame_done, missed;
    logic [15:0] spawn_x = 0, spawn_y = 0, rd_cx, rd_cy, rd_r;
    logic [7:0] spawn_vx = 0, spawn_vy = 0, active;
    logic [2:0] rd_idx = 0;
    int total = 0, bad = 0;
    int mpx[N], mpy[N], mvx[N], mvy[N];
    bit mex[N], mact[N];

    ball_pool dut (
        .i_clk(clk), .i_rst(rst), .i_ani_stb(ani_stb), .i_animate(animate),
        .i_spawn_valid(spawn_valid), .o_spawn_ready(spawn_ready),
        .i_spawn_x(spawn_x), .i_spawn_y(spawn_y), .i_spawn_vx(spawn_vx), .i_spawn_vy(spawn_vy),
        .i_spawn_mode(spawn_mode), .i_rd_idx(rd_idx), .o_rd_cx(rd_cx), .o_rd_cy(rd_cy),
        .o_rd_r(rd_r), .o_rd_active(rd_active), .o_active(active), .o_busy(busy),
        .o_frame_done(frame_done), .o_missed(missed)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    function automatic logic [7:0] model_bits();
        logic [7:0] b = '0;
        for (int i = 0; i < N; i++) b[i] = mact[i];
        return b;
    endfunction

    task automatic model_axis(inout int p, inout int v, input int hi, input bit ex_mode, output bit gone);
        int n = p + v;
        gone = 0;
        if (n < LO || n > hi) begin
            if (ex_mode) gone = 1;
            else begin
                p = n < LO ? LO : hi;
                v = (v == -128) ? 127 : -v;
            end
        end else p = n;
    endtask

    task automatic model_sweep();
        bit gx, gy;
        for (int i = 0; i < N; i++) if (mact[i]) begin
            model_axis(mpx[i], mvx[i], HIX, mex[i], gx);
            model_axis(mpy[i], mvy[i], HIY, mex[i], gy);
            if (gx || gy) mact[i] = 0;
        end
    endtask

    task automatic model_spawn(input int x, input int y, input int vx, input int vy, input bit m);
        int s = -1;
        for (int i = N - 1; i >= 0; i--) if (!mact[i]) s = i;
        if (s >= 0) begin
            mact[s] = 1; mex[s] = m; mvx[s] = vx; mvy[s] = vy;
            mpx[s] = clampi(x, R, FW - R) * 16;
            mpy[s] = clampi(y, R, FH - R) * 16;
        end
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0; #1;
        for (int i = 0; i < N; i++) mact[i] = 0;
    endtask

    task automatic spawn(input int x, input int y, input int vx, input int vy, input bit m);
        spawn_x = 16'(x); spawn_y = 16'(y); spawn_vx = 8'(vx); spawn_vy = 8'(vy); spawn_mode = m;
        spawn_valid = 1;
        total++; if (spawn_ready !== 1'b1) begin bad++; $display("FAIL spawn_ready got=%b want=1", spawn_ready); end
        step();
        spawn_valid = 0;
        model_spawn(x, y, vx, vy, m);
    endtask

    task automatic run_frame();
        int n = 1;
        ani_stb = 1; step(); ani_stb = 0;
        while (!frame_done && n < 50) begin step(); n++; end
        model_sweep();
        total++; if (n != N + 1) begin bad++; $display("FAIL frame_latency got=%0d want=%0d", n, N + 1); end
    endtask

    task automatic rd(input int i);
        rd_idx = 3'(i); step();
    endtask

    task automatic test_reset();
        rst = 1; step(); step();
        total++; if (spawn_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", spawn_ready); end
        total++; if (active !== 8'h00) begin bad++; $display("FAIL rst_active got=%h want=00", active); end
        total++; if ({busy, frame_done, missed} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {busy, frame_done, missed}); end
        total++; if ({rd_cx, rd_cy, rd_r, rd_active} !== 49'd0) begin bad++; $display("FAIL rst_rd got=%0d/%0d/%0d want=0", rd_cx, rd_cy, rd_r); end
        rst = 0; #1;
        total++; if (spawn_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", spawn_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        spawn(10, 20, 16, 0, 0);
        total++; if (active !== 8'h01) begin bad++; $display("FAIL spawn_active got=%h want=01", active); end
        run_frame();
        rd(0);
        total++; if (rd_cx !== 16'd256 || rd_cy !== 16'd250) begin bad++; $display("FAIL basic_pos got=%0d,%0d want=256,250", rd_cx, rd_cy); end
        total++; if (rd_active !== 1'b1 || rd_r !== 16'd5) begin bad++; $display("FAIL basic_act_r got=%b,%0d want=1,5", rd_active, rd_r); end
    endtask

    task automatic test_subpixel();
        do_reset();
        spawn(10, 20, 8, 0, 0);
        run_frame(); rd(0);
        total++; if (rd_cx !== 16'd255) begin bad++; $display("FAIL subpix1 got=%0d want=255", rd_cx); end
        run_frame(); rd(0);
        total++; if (rd_cx !== 16'd256) begin bad++; $display("FAIL subpix2 got=%0d want=256", rd_cx); end
    endtask

    task automatic test_bounce();
        do_reset();
        spawn(144, 20, 32, 0, 0);
        spawn(6, 20, -32, 0, 0);
        spawn(5, 20, -128, 0, 0);
        spawn(200, 0, 0, 0, 0);
        rd(3);
        total++; if (rd_cx !== 16'd390 || rd_cy !== 16'd235) begin bad++; $display("FAIL clamp got=%0d,%0d want=390,235", rd_cx, rd_cy); end
        run_frame();
        rd(0); total++; if (rd_cx !== 16'd390) begin bad++; $display("FAIL bounce_hi got=%0d want=390", rd_cx); end
        rd(1); total++; if (rd_cx !== 16'd250) begin bad++; $display("FAIL bounce_lo got=%0d want=250", rd_cx); end
        rd(2); total++; if (rd_cx !== 16'd250) begin bad++; $display("FAIL bounce_min got=%0d want=250", rd_cx); end
        run_frame();
        rd(0); total++; if (rd_cx !== 16'd388) begin bad++; $display("FAIL bounce_back got=%0d want=388", rd_cx); end
        rd(1); total++; if (rd_cx !== 16'd252) begin bad++; $display("FAIL bounce_lo2 got=%0d want=252", rd_cx); end
        rd(2); total++; if (rd_cx !== 16'd257) begin bad++; $display("FAIL neg_sat got=%0d want=257", rd_cx); end
        rd(3); total++; if (rd_cx !== 16'd390) begin bad++; $display("FAIL v0_still got=%0d want=390", rd_cx); end
    endtask

    task automatic test_exit_full();
        int n = 1;
        do_reset();
        for (int i = 0; i < N; i++) spawn(i == 3 ? 144 : 20, 20, i == 3 ? 32 : 0, 0, i == 3);
        total++; if (spawn_ready !== 1'b0 || active !== 8'hff) begin bad++; $display("FAIL full got=%b,%h want=0,ff", spawn_ready, active); end
        ani_stb = 1; step(); ani_stb = 0;
        while (!frame_done && n < 50) begin
            step(); n++;
            if (n == 4) begin total++; if (active[3] !== 1'b1) begin bad++; $display("FAIL exit_early got=%b want=1", active[3]); end end
            if (n == 5) begin total++; if (active[3] !== 1'b0) begin bad++; $display("FAIL exit_clear got=%b want=0", active[3]); end end
        end
        model_sweep();
        total++; if (n != N + 1 || active !== 8'hf7) begin bad++; $display("FAIL exit_frame got=%0d,%h want=9,f7", n, active); end
        spawn(50, 60, 0, 0, 0);
        total++; if (active !== 8'hff) begin bad++; $display("FAIL refill got=%h want=ff", active); end
        rd(3);
        total++; if (rd_cx !== 16'd295 || rd_cy !== 16'd290) begin bad++; $display("FAIL refill_pos got=%0d,%0d want=295,290", rd_cx, rd_cy); end
    endtask

    task automatic test_missed();
        int n = 1, cnt = 0;
        do_reset();
        spawn(10, 20, 16, 16, 0);
        ani_stb = 1; step(); ani_stb = 0;
        while (!frame_done && n < 50) begin
            ani_stb = (n == 4); step(); n++;
            if (missed) cnt++;
        end
        ani_stb = 0;
        model_sweep();
        total++; if (n != N + 1 || cnt != 1) begin bad++; $display("FAIL missed got=%0d,%0d want=9,1", n, cnt); end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL missed_nosweep got=%b want=0", busy); end
        rd(0);
        total++; if (rd_cx !== 16'd256 || rd_cy !== 16'd251) begin bad++; $display("FAIL missed_pos got=%0d,%0d want=256,251", rd_cx, rd_cy); end
        spawn_x = 30; spawn_y = 40; spawn_vx = 8'd16; spawn_vy = 8'hf0; spawn_mode = 0;
        spawn_valid = 1; ani_stb = 1; step(); spawn_valid = 0; ani_stb = 0;
        n = 1;
        while (!frame_done && n < 50) begin step(); n++; end
        model_spawn(30, 40, 16, -16, 0); model_sweep();
        rd(1);
        total++; if (rd_cx !== 16'd276 || rd_cy !== 16'd269 || n != N + 1) begin bad++; $display("FAIL spawn_stb got=%0d,%0d,%0d want=276,269,9", rd_cx, rd_cy, n); end
        animate = 0; ani_stb = 1; step(); ani_stb = 0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL animate_low_busy got=%b want=0", busy); end
        step();
        total++; if (missed !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL animate_low got=%b,%b want=0,0", missed, busy); end
        animate = 1;
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        do_reset();
        spawn(10, 20, 16, 0, 0); spawn(30, 30, 0, 16, 1);
        ani_stb = 1; step(); ani_stb = 0; step(); step();
        rst = 1; #1;
        total++; if (spawn_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b want=0", spawn_ready); end
        step();
        total++; if (active !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL midrst got=%h,%b want=00,0", active, busy); end
        rst = 0; #1;
        for (int i = 0; i < N; i++) mact[i] = 0;
        total++; if (spawn_ready !== 1'b1 || rd_cx !== 16'd0) begin bad++; $display("FAIL midrst_after got=%b,%0d want=1,0", spawn_ready, rd_cx); end
        for (int i = 0; i < 12; i++) begin step(); if (frame_done || busy) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL midrst_stale got=%0d want=0", seen); end
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 14; f++) begin
            int k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                int vx = (($urandom % 8) == 0) ? -128 : $urandom_range(0, 255) - 128;
                if (model_bits() != 8'hff)
                    spawn($urandom_range(0, 170), $urandom_range(0, 170), vx,
                          $urandom_range(0, 255) - 128, ($urandom % 4) == 0);
            end
            run_frame();
            total++; if (active !== model_bits()) begin bad++; $display("FAIL rnd_active f=%0d got=%h want=%h", f, active, model_bits()); end
            for (int i = 0; i < N; i++) begin
                rd(i);
                total++; if (rd_active !== mact[i]) begin bad++; $display("FAIL rnd_act f=%0d s=%0d got=%b want=%b", f, i, rd_active, mact[i]); end
                if (mact[i]) begin
                    total++;
                    if (rd_cx !== 16'(FX + mpx[i] / 16) || rd_cy !== 16'(FY + mpy[i] / 16)) begin
                        bad++; $display("FAIL rnd_pos f=%0d s=%0d got=%0d,%0d want=%0d,%0d", f, i, rd_cx, rd_cy, FX + mpx[i] / 16, FY + mpy[i] / 16);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_subpixel();
        test_bounce();
        test_exit_full();
        test_missed();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ball_pool.md
# ball_pool

Parametrised multi-projectile engine for the fighting box. It holds up to N_BALLS independent balls with signed sub-pixel velocities and a per-ball mode: bounce off the box walls, or despawn on exit. On each animation strobe, one time-multiplexed datapath sweeps every ball, one per cycle. Game logic launches balls through a valid/ready spawn port, and the renderer reads ball state through an indexed read port.

## Interface
- N_BALLS, 8, number of ball slots (≥1)
- W, 16, integer pixel coordinate width
- FRAC, 4, fractional bits of position and velocity
- VW, 8, signed velocity width (in 1/2^FRAC px per frame)
- FX, 245 / FY, 230, screen coordinate of the box's top-left corner
- F_WIDTH, 150 / F_HEIGHT, 150, box size in pixels
- R, 5, ball radius in pixels (same for all balls)
- i_clk  in  1  base clock
- i_rst  in  1  reset; synchronous, active-high; clock i_clk
- i_ani_stb  in  1  one-cycle frame strobe
- i_animate  in  1  strobe is honoured only when high
- i_spawn_valid  in  1  spawn request
- o_spawn_ready  out  1  spawn accepted when valid && ready
- i_spawn_x, i_spawn_y  in  W  integer start position, relative to box
- i_spawn_vx, i_spawn_vy  in  VW  signed velocity, fixed point
- i_spawn_mode  in  1  0 = BOUNCE, 1 = EXIT
- i_rd_idx  in  clog2(N_BALLS)  read slot select
- o_rd_cx, o_rd_cy  out  W  screen centre: FX/FY plus the integer part of the position
- o_rd_r  out  W  radius R
- o_rd_active  out  1  selected slot is live
- o_active  out  N_BALLS  live bitmap
- o_busy  out  1  sweep in progress
- o_frame_done  out  1  one-cycle pulse when a sweep completes
- o_missed  out  1  one-cycle pulse when a strobe arrives during a sweep

## Operation
- **FSM states:** IDLE and SWEEP.
  - IDLE → SWEEP when i_ani_stb && i_animate; the sweep index is set to 0.
  - SWEEP updates slot idx each cycle, then increments idx.
  - After slot N_BALLS-1, SWEEP → IDLE and o_frame_done pulses.
- **Spawn:** o_spawn_ready = IDLE && !i_rst && at least one slot free.
  - The ball goes into the lowest-index free slot.
  - Spawn positions are clamped to the legal range [R, F_WIDTH-R] and [R, F_HEIGHT-R].
  - The fractional part of the position is cleared on spawn.
- **Simultaneous spawn and strobe in IDLE:** both take effect. The new ball is written that cycle and is updated by the sweep that starts next cycle.
- **Per-axis update** (identical for x and y; lo = R<<FRAC, hi = (F_SIZE-R)<<FRAC):
  - nxt = pos + sign-extended v, computed at W+FRAC+2 bits signed so it never wraps.
  - BOUNCE mode: if nxt < lo, then pos = lo and v = -v. If nxt > hi, then pos = hi and v = -v. Otherwise pos = nxt.
  - EXIT mode: if nxt < lo or nxt > hi, the slot is deactivated and pos is left unchanged. Otherwise pos = nxt.
  - Negating -2^(VW-1) saturates to 2^(VW-1)-1.
  - v = 0 never moves and never bounces.
- Inactive slots are skipped; the sweep still takes one cycle per slot.
- A strobe during SWEEP is ignored and o_missed pulses.
- i_animate low: strobes are ignored silently, with no o_missed pulse.

## Timing
- **Reset** (any state, including mid-sweep), next cycle:
  - o_active = 0, FSM in IDLE, idx = 0.
  - o_busy, o_frame_done and o_missed = 0.
  - o_rd_* = 0.
  - o_spawn_ready is 0 while i_rst is high and 1 in the first cycle after.
  - Slot contents are don't-care, since every slot is inactive.
- **Spawn latency:** handshake in cycle t → o_active bit set at t+1.
- **Sweep:** strobe in cycle t → o_busy high from t+1 through t+N_BALLS. Slot k is written at the end of cycle t+1+k. o_frame_done pulses in cycle t+N_BALLS+1, when o_busy is already low.
  - Frame period must be ≥ N_BALLS+1 cycles.
- **Read port:** registered. i_rd_idx in cycle t → o_rd_* valid in t+1.
  - Reads during a sweep return whatever is stored at that moment; there is no coherency guarantee.
- **Deactivation:** o_active reflects an EXIT deactivation one cycle after that slot's update.

## Structure
- **Package ball_pkg:**
  - mode enum (BOUNCE, EXIT) and FSM state enum (IDLE, SWEEP).
  - Fixed-point helper constants: position width W+FRAC, guard width W+FRAC+2.
- **Sub-module ball_axis_step:** combinational single-axis update.
  - Inputs: pos, v, lo, hi, mode. Outputs: pos', v', exit.
  - Instantiated twice (x and y). A ball exits if either axis exits.
- Slot storage is register arrays indexed by the sweep index; it is RAM-inferable.

## Test plan
- **Basic move:** reset, then spawn x=10, y=20, vx=+16, vy=0, BOUNCE; one strobe → slot 0 reads cx=256, cy=250, active=1; o_frame_done pulses 9 cycles after the strobe.
- **Sub-pixel:** vx=+8 from x=10 → cx stays 255 after one strobe and reads 256 after the second.
- **Bounce:** x=144, vx=+32 → after one frame cx=245+145=390 and vx=-32; after the next frame cx=388. Mirror case: x=6, vx=-32 → clamps to 250.
- **Exit and full:** x=144, vx=+32, EXIT → o_active[0]=0 after the frame. Fill 8 slots → o_spawn_ready=0. Let slot 3 exit → the next spawn lands in slot 3.
- **Missed strobe:** strobe again at sweep cycle 4 → o_missed pulses once and the sweep still finishes at t+8. Spawn and strobe in the same cycle → the new ball has moved by one step after the sweep.
- **Mid-sweep reset:** assert i_rst at sweep cycle 3 → next cycle o_active=0 and o_busy=0; o_spawn_ready=1 the cycle after i_rst drops.
